pd_rx_deframer: RTL and testbench
=================================

Name: pd_rx_deframer

Overview:
Receive-side USB-PD physical-layer deframer. It takes the recovered serial bit stream from the BMC decoder, one bit per qualified clock, least-significant bit of each 5b symbol first. It hunts for an ordered set, aligns to the symbol boundary, decodes 5b symbols to 4b nibbles, and assembles bytes (low nibble first). It reports SOP type, data bytes, EOP, Hard/Cable Reset and framing errors to the protocol layer.

Parameters:
MAX_BYTES, 8'd36, payload byte limit (header + data + CRC) before an overrun error.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
bit_in  in  1  recovered line bit, sampled when bit_vld=1
bit_vld  in  1  single-cycle qualifier per received bit
rx_active  in  1  BMC carrier present; 0 = idle/squelch
sop_det  out  1  one-cycle pulse: SOP/SOP'/SOP'' recognised
sop_type  out  2  0=SOP, 1=SOP', 2=SOP''; held until next sop_det
rx_data  out  8  received byte; held until next rx_data_vld
rx_data_vld  out  1  one-cycle pulse per byte
eop  out  1  one-cycle pulse: EOP on byte boundary
hrst_det  out  1  one-cycle pulse: Hard Reset ordered set
crst_det  out  1  one-cycle pulse: Cable Reset ordered set
rx_err  out  1  one-cycle pulse: frame aborted
busy  out  1  1 while in DATA state

Behaviour:
- One clock (clk). rst is synchronous and active-high. All outputs reset to 0, FSM resets to HUNT, and shift/count registers clear.
- Symbol bit order: first received bit lands in symbol bit 0. Shift is {bit_in, sr[19:1]}, so sr[4:0] holds the oldest symbol.
- K-codes (bit 4..0): Sync-1 11000, Sync-2 10001, Sync-3 00110, RST-1 00111, RST-2 11001, EOP 01101. Data codes are the standard 4b5b table (0→11110 … F→11101).
- HUNT: on every bit_vld, compare the 20-bit window (4 symbols, first-received in sr[4:0]) against the ordered sets. Exact 4-of-4 match is required; 3-of-4 tolerance is not implemented.
  - SOP = S1,S1,S1,S2
  - SOP' = S1,S1,S3,S3
  - SOP'' = S1,S3,S1,S3
  - Hard Reset = R1,R1,R1,R2
  - Cable Reset = R1,S1,R1,S3
- HUNT match outcomes, each registered and asserted the cycle after the matching bit_vld:
  - SOP-class match: sop_det=1, update sop_type, go to DATA, clear bit counter (0..4), nibble phase, byte count.
  - Hard or Cable Reset: pulse hrst_det or crst_det, stay in HUNT, clear window.
- DATA: a symbol completes on every 5th bit_vld. It is decoded through dec_5b4b, and the result is registered one cycle after the completing bit_vld.
  - Data symbol, phase 0: latch low nibble.
  - Data symbol, phase 1: rx_data={hi,lo}, rx_data_vld=1, byte_count+1.
  - EOP with phase 0: eop=1, go to HUNT.
  - EOP with phase 1 (odd nibble count): rx_err=1, go to HUNT; no eop.
  - Any other K-code or invalid 5b code: rx_err=1, go to HUNT.
  - byte_count reaching MAX_BYTES and then receiving a further data symbol: rx_err=1, go to HUNT.
- rx_active falling while in DATA: rx_err=1 next cycle, go to HUNT, discard the partial nibble. In HUNT, rx_active=0 clears the window.
- bit_vld and rx_active falling in the same cycle: the abort wins and the bit is ignored.
- At most one of sop_det/rx_data_vld/eop/hrst_det/crst_det/rx_err pulses per cycle.
- Latency: last bit of a symbol to its output pulse is 1 clk.
- bit_vld is allowed every cycle. No backpressure; the consumer must accept each pulse.
- rst mid-frame: immediate return to HUNT, no error pulse.

Decomposition:
- Package pd_4b5b_pkg:
  - 5b K-code localparams (K_SYNC1, K_SYNC2, K_SYNC3, K_RST1, K_RST2, K_EOP)
  - the four-symbol ordered-set 20-bit constants
  - SOP type codes
  - FSM state encoding (HUNT, DATA)
- Sub-module dec_5b4b: combinational inverse of the transmit encoder. Input 5b; outputs nibble[3:0], is_data, is_kcode, kcode_id[2:0]; invalid = neither.

Test Plan:
- Preamble of 64 alternating bits, SOP, data nibbles 1,2 and 3,4, EOP → sop_det with sop_type=0, rx_data=8'h21 then 8'h43, eop one cycle after the last EOP bit; no rx_err.
- SOP' then SOP'' each followed by EOP (zero payload) → sop_type=1 then 2, eop each time, no rx_data_vld.
- Hard Reset R1,R1,R1,R2 after preamble → hrst_det single pulse, busy stays 0. Cable Reset → crst_det single pulse.
- SOP, data 5, EOP (odd nibble count) → rx_err, no eop, no rx_data_vld. Then SOP, data A,B, EOP → rx_data=8'hBA, eop.
- SOP then invalid symbol 00000 → rx_err and return to HUNT. Separately, SOP, 2 nibbles, then rx_active=0 → rx_err and busy=0.
- MAX_BYTES=2: SOP, 3 bytes → two rx_data_vld then rx_err on the 5th nibble. Also assert rst mid-byte → all outputs 0, no pulse.

Source files
------------

// File: rtl/pd_4b5b_pkg.sv
// USB-PD 4b5b line-code constants: K-codes, ordered sets, SOP type codes, deframer states.
// No logic; shared by the receive deframer and its symbol decoder.
// Backpressure: not applicable.
package pd_4b5b_pkg;

    localparam logic [4:0] K_SYNC1 = 5'b11000;
    localparam logic [4:0] K_SYNC2 = 5'b10001;
    localparam logic [4:0] K_SYNC3 = 5'b00110;
    localparam logic [4:0] K_RST1  = 5'b00111;
    localparam logic [4:0] K_RST2  = 5'b11001;
    localparam logic [4:0] K_EOP   = 5'b01101;

    localparam logic [2:0] KID_SYNC1 = 3'd0;
    localparam logic [2:0] KID_SYNC2 = 3'd1;
    localparam logic [2:0] KID_SYNC3 = 3'd2;
    localparam logic [2:0] KID_RST1  = 3'd3;
    localparam logic [2:0] KID_RST2  = 3'd4;
    localparam logic [2:0] KID_EOP   = 3'd5;

    // First symbol on the wire sits in bits [4:0].
    localparam logic [19:0] OS_SOP    = {K_SYNC2, K_SYNC1, K_SYNC1, K_SYNC1};
    localparam logic [19:0] OS_SOP_P  = {K_SYNC3, K_SYNC3, K_SYNC1, K_SYNC1};
    localparam logic [19:0] OS_SOP_PP = {K_SYNC3, K_SYNC1, K_SYNC3, K_SYNC1};
    localparam logic [19:0] OS_HRST   = {K_RST2,  K_RST1,  K_RST1,  K_RST1};
    localparam logic [19:0] OS_CRST   = {K_SYNC3, K_RST1,  K_SYNC1, K_RST1};

    typedef enum logic [1:0] {
        SOP_T_SOP    = 2'd0,
        SOP_T_SOP_P  = 2'd1,
        SOP_T_SOP_PP = 2'd2
    } sop_type_e;

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

endpackage

// File: rtl/dec_5b4b.sv
// 5b symbol decoder: maps a symbol to a data nibble or a K-code id; anything else is invalid.
// Latency: purely combinational.
// Backpressure: none.
module dec_5b4b
    import pd_4b5b_pkg::*;
(
    input  logic [4:0] sym,
    output logic [3:0] nibble,
    output logic       is_data,
    output logic       is_kcode,
    output logic [2:0] kcode_id
);

    always_comb begin
        nibble   = 4'h0;
        is_data  = 1'b1;
        is_kcode = 1'b0;
        kcode_id = 3'd0;
        case (sym)
            5'b11110: nibble = 4'h0;
            5'b01001: nibble = 4'h1;
            5'b10100: nibble = 4'h2;
            5'b10101: nibble = 4'h3;
            5'b01010: nibble = 4'h4;
            5'b01011: nibble = 4'h5;
            5'b01110: nibble = 4'h6;
            5'b01111: nibble = 4'h7;
            5'b10010: nibble = 4'h8;
            5'b10011: nibble = 4'h9;
            5'b10110: nibble = 4'hA;
            5'b10111: nibble = 4'hB;
            5'b11010: nibble = 4'hC;
            5'b11011: nibble = 4'hD;
            5'b11100: nibble = 4'hE;
            5'b11101: nibble = 4'hF;
            default:  is_data = 1'b0;
        endcase

        case (sym)
            K_SYNC1: begin is_kcode = 1'b1; kcode_id = KID_SYNC1; end
            K_SYNC2: begin is_kcode = 1'b1; kcode_id = KID_SYNC2; end
            K_SYNC3: begin is_kcode = 1'b1; kcode_id = KID_SYNC3; end
            K_RST1:  begin is_kcode = 1'b1; kcode_id = KID_RST1;  end
            K_RST2:  begin is_kcode = 1'b1; kcode_id = KID_RST2;  end
            K_EOP:   begin is_kcode = 1'b1; kcode_id = KID_EOP;   end
            default: ;
        endcase
    end

endmodule

// File: rtl/pd_rx_deframer.sv
// USB-PD receive deframer: ordered-set hunt, 5b symbol alignment, 4b5b decode, byte assembly.
// Latency: 1 clk from the last bit of a symbol to its output pulse.
// Backpressure: none; every output pulse must be taken by the consumer that cycle.
module pd_rx_deframer
    import pd_4b5b_pkg::*;
#(
    parameter logic [7:0] MAX_BYTES = 8'd36
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_vld,
    input  logic       rx_active,
    output logic       sop_det,
    output logic [1:0] sop_type,
    output logic [7:0] rx_data,
    output logic       rx_data_vld,
    output logic       eop,
    output logic       hrst_det,
    output logic       crst_det,
    output logic       rx_err,
    output logic       busy
);

    // The newest bit completes the 20-bit window, so only 19 older bits need storing.
    logic [18:0] sr_q, sr_d;
    logic [19:0] win;
    logic [0:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        phase_q, phase_d;
    logic [3:0]  lo_q, lo_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [1:0]  sop_type_q, sop_type_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        sop_det_q, sop_det_d;
    logic        rx_data_vld_q, rx_data_vld_d;
    logic        eop_q, eop_d;
    logic        hrst_det_q, hrst_det_d;
    logic        crst_det_q, crst_det_d;
    logic        rx_err_q, rx_err_d;
    logic        abort;
    logic        go_hunt;

    logic [3:0] dec_nib;
    logic       dec_is_data;
    logic       dec_is_k;
    logic [2:0] dec_kid;

    assign win = {bit_in, sr_q};

    dec_5b4b u_dec (
        .sym      (win[19:15]),
        .nibble   (dec_nib),
        .is_data  (dec_is_data),
        .is_kcode (dec_is_k),
        .kcode_id (dec_kid)
    );

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        phase_d       = phase_q;
        lo_d          = lo_q;
        byte_cnt_d    = byte_cnt_q;
        sop_type_d    = sop_type_q;
        rx_data_d     = rx_data_q;
        sop_det_d     = 1'b0;
        rx_data_vld_d = 1'b0;
        eop_d         = 1'b0;
        hrst_det_d    = 1'b0;
        crst_det_d    = 1'b0;
        rx_err_d      = 1'b0;
        abort         = 1'b0;
        go_hunt       = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (!rx_active) begin
                    sr_d = '0;
                end else if (bit_vld) begin
                    sr_d = win[19:1];
                    if (win == OS_SOP || win == OS_SOP_P || win == OS_SOP_PP) begin
                        sop_det_d  = 1'b1;
                        state_d    = ST_DATA;
                        sr_d       = '0;
                        bit_cnt_d  = 3'd0;
                        phase_d    = 1'b0;
                        lo_d       = 4'h0;
                        byte_cnt_d = 8'd0;
                        if (win == OS_SOP_P)       sop_type_d = SOP_T_SOP_P;
                        else if (win == OS_SOP_PP) sop_type_d = SOP_T_SOP_PP;
                        else                       sop_type_d = SOP_T_SOP;
                    end else if (win == OS_HRST) begin
                        hrst_det_d = 1'b1;
                        sr_d       = '0;
                    end else if (win == OS_CRST) begin
                        crst_det_d = 1'b1;
                        sr_d       = '0;
                    end
                end
            end
            default: begin
                if (!rx_active) begin
                    abort = 1'b1;
                end else if (bit_vld) begin
                    sr_d = win[19:1];
                    if (bit_cnt_q == 3'd4) begin
                        bit_cnt_d = 3'd0;
                        if (dec_is_data) begin
                            if (byte_cnt_q >= MAX_BYTES) begin
                                abort = 1'b1;
                            end else if (!phase_q) begin
                                lo_d    = dec_nib;
                                phase_d = 1'b1;
                            end else begin
                                rx_data_d     = {dec_nib, lo_q};
                                rx_data_vld_d = 1'b1;
                                byte_cnt_d    = byte_cnt_q + 8'd1;
                                phase_d       = 1'b0;
                            end
                        end else if (dec_is_k && dec_kid == KID_EOP && !phase_q) begin
                            eop_d   = 1'b1;
                            go_hunt = 1'b1;
                        end else begin
                            // Stray K-code, invalid code, or EOP after an odd nibble count.
                            abort = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
        endcase

        if (abort) begin
            rx_err_d = 1'b1;
            go_hunt  = 1'b1;
        end
        if (go_hunt) begin
            state_d = ST_HUNT;
            sr_d    = '0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            sr_q          <= '0;
            bit_cnt_q     <= 3'd0;
            phase_q       <= 1'b0;
            lo_q          <= 4'h0;
            byte_cnt_q    <= 8'd0;
            sop_type_q    <= 2'd0;
            rx_data_q     <= 8'd0;
            sop_det_q     <= 1'b0;
            rx_data_vld_q <= 1'b0;
            eop_q         <= 1'b0;
            hrst_det_q    <= 1'b0;
            crst_det_q    <= 1'b0;
            rx_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            phase_q       <= phase_d;
            lo_q          <= lo_d;
            byte_cnt_q    <= byte_cnt_d;
            sop_type_q    <= sop_type_d;
            rx_data_q     <= rx_data_d;
            sop_det_q     <= sop_det_d;
            rx_data_vld_q <= rx_data_vld_d;
            eop_q         <= eop_d;
            hrst_det_q    <= hrst_det_d;
            crst_det_q    <= crst_det_d;
            rx_err_q      <= rx_err_d;
        end
    end

    assign sop_det     = sop_det_q;
    assign sop_type    = sop_type_q;
    assign rx_data     = rx_data_q;
    assign rx_data_vld = rx_data_vld_q;
    assign eop         = eop_q;
    assign hrst_det    = hrst_det_q;
    assign crst_det    = crst_det_q;
    assign rx_err      = rx_err_q;
    assign busy        = (state_q == ST_DATA);

endmodule

// File: tb/tb_pd_rx_deframer.sv
// Scoreboard bench for pd_rx_deframer: directed frames push expected pulses, a monitor pops and compares.
module tb_pd_rx_deframer;
    import pd_4b5b_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_vld = 1'b0;
    logic       rx_active = 1'b1;
    logic       sop_det;
    logic [1:0] sop_type;
    logic [7:0] rx_data;
    logic       rx_data_vld;
    logic       eop;
    logic       hrst_det;
    logic       crst_det;
    logic       rx_err;
    logic       busy;

    pd_rx_deframer #(.MAX_BYTES(8'd2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_vld     (bit_vld),
        .rx_active   (rx_active),
        .sop_det     (sop_det),
        .sop_type    (sop_type),
        .rx_data     (rx_data),
        .rx_data_vld (rx_data_vld),
        .eop         (eop),
        .hrst_det    (hrst_det),
        .crst_det    (crst_det),
        .rx_err      (rx_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int EV_NONE = -1;
    localparam int EV_SOP  = 0;
    localparam int EV_DATA = 1;
    localparam int EV_EOP  = 2;
    localparam int EV_HRST = 3;
    localparam int EV_CRST = 4;
    localparam int EV_ERR  = 5;

    typedef struct {
        int         kind;
        logic [7:0] dat;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_pass = 0;

    logic [4:0] d5 [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                            5'b01010, 5'b01011, 5'b01110, 5'b01111,
                            5'b10010, 5'b10011, 5'b10110, 5'b10111,
                            5'b11010, 5'b11011, 5'b11100, 5'b11101};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    endtask

    task automatic push_ev(input int kind, input logic [7:0] dat);
        ev_t e;
        e.kind = kind;
        e.dat  = dat;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input int kind, input logic [7:0] dat);
        @(negedge clk);
        bit_in  = b;
        bit_vld = 1'b1;
        if (kind != EV_NONE) push_ev(kind, dat);
    endtask

    task automatic send_sym(input logic [4:0] s, input int kind, input logic [7:0] dat);
        for (int i = 0; i < 5; i++) send_bit(s[i], (i == 4) ? kind : EV_NONE, dat);
    endtask

    task automatic send_os(input logic [19:0] os, input int kind, input logic [7:0] dat);
        for (int j = 0; j < 4; j++) send_sym(os[j*5 +: 5], (j == 3) ? kind : EV_NONE, dat);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_vld = 1'b0;
        end
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) send_bit(i[0], EV_NONE, 8'd0);
    endtask

    // Monitor: one pulse at most per cycle, each matched in order and on time.
    always @(negedge clk) begin : mon
        int   n;
        int   kind;
        logic [7:0] dat;
        ev_t  e;
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("missed_event", EV_NONE, e.kind);
            end
            n = int'(sop_det) + int'(rx_data_vld) + int'(eop) + int'(hrst_det)
              + int'(crst_det) + int'(rx_err);
            if (n > 1) begin
                chk("single_pulse", n, 1);
            end else if (n == 1) begin
                kind = sop_det ? EV_SOP : rx_data_vld ? EV_DATA : eop ? EV_EOP :
                       hrst_det ? EV_HRST : crst_det ? EV_CRST : EV_ERR;
                dat  = sop_det ? {6'd0, sop_type} : rx_data_vld ? rx_data : 8'd0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", kind, EV_NONE);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_kind", kind, e.kind);
                    chk("ev_data", dat, e.dat);
                    chk("ev_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pulses", {sop_det, rx_data_vld, eop, hrst_det, crst_det, rx_err}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sop_type", sop_type, 0);
        chk("rst_rx_data", rx_data, 0);
        rst = 1'b0;

        // SOP with two bytes
        preamble(64);
        send_os(OS_SOP, EV_SOP, 8'd0);
        idle(1);
        chk("busy_in_data", busy, 1);
        send_sym(d5[1], EV_NONE, 8'd0);
        send_sym(d5[2], EV_DATA, 8'h21);
        send_sym(d5[3], EV_NONE, 8'd0);
        send_sym(d5[4], EV_DATA, 8'h43);
        send_sym(K_EOP, EV_EOP, 8'd0);
        idle(3);
        chk("busy_after_eop", busy, 0);

        // SOP' and SOP'' with empty payload
        preamble(16);
        send_os(OS_SOP_P, EV_SOP, 8'd1);
        send_sym(K_EOP, EV_EOP, 8'd0);
        idle(3);
        chk("sop_type_held", sop_type, 1);
        preamble(16);
        send_os(OS_SOP_PP, EV_SOP, 8'd2);
        send_sym(K_EOP, EV_EOP, 8'd0);
        idle(3);

        // Hard and Cable Reset
        preamble(16);
        send_os(OS_HRST, EV_HRST, 8'd0);
        idle(1);
        chk("busy_after_hrst", busy, 0);
        idle(2);
        preamble(16);
        send_os(OS_CRST, EV_CRST, 8'd0);
        idle(1);
        chk("busy_after_crst", busy, 0);
        idle(2);

        // Odd nibble count, then a good one-byte frame
        preamble(16);
        send_os(OS_SOP, EV_SOP, 8'd0);
        send_sym(d5[5], EV_NONE, 8'd0);
        send_sym(K_EOP, EV_ERR, 8'd0);
        idle(3);
        chk("busy_after_odd", busy, 0);
        preamble(16);
        send_os(OS_SOP, EV_SOP, 8'd0);
        send_sym(d5[10], EV_NONE, 8'd0);
        send_sym(d5[11], EV_DATA, 8'hBA);
        send_sym(K_EOP, EV_EOP, 8'd0);
        idle(3);
        chk("rx_data_held", rx_data, 8'hBA);

        // Invalid symbol
        preamble(16);
        send_os(OS_SOP, EV_SOP, 8'd0);
        send_sym(5'b00000, EV_ERR, 8'd0);
        idle(3);
        chk("busy_after_invalid", busy, 0);

        // Carrier loss after one byte
        preamble(16);
        send_os(OS_SOP, EV_SOP, 8'd0);
        send_sym(d5[1], EV_NONE, 8'd0);
        send_sym(d5[2], EV_DATA, 8'h21);
        idle(1);
        chk("busy_before_drop", busy, 1);
        @(negedge clk);
        rx_active = 1'b0;
        bit_vld   = 1'b0;
        push_ev(EV_ERR, 8'd0);
        idle(2);
        rx_active = 1'b1;
        chk("busy_after_drop", busy, 0);

        // Carrier loss coinciding with a bit, partial nibble discarded
        preamble(16);
        send_os(OS_SOP, EV_SOP, 8'd0);
        send_sym(d5[3], EV_NONE, 8'd0);
        send_bit(1'b1, EV_NONE, 8'd0);
        send_bit(1'b0, EV_NONE, 8'd0);
        @(negedge clk);
        rx_active = 1'b0;
        bit_vld   = 1'b1;
        bit_in    = 1'b1;
        push_ev(EV_ERR, 8'd0);
        idle(2);
        rx_active = 1'b1;
        chk("rx_data_after_abort", rx_data, 8'h21);

        // Overrun with a two-byte limit
        preamble(16);
        send_os(OS_SOP, EV_SOP, 8'd0);
        send_sym(d5[1], EV_NONE, 8'd0);
        send_sym(d5[2], EV_DATA, 8'h21);
        send_sym(d5[3], EV_NONE, 8'd0);
        send_sym(d5[4], EV_DATA, 8'h43);
        send_sym(d5[5], EV_ERR, 8'd0);
        idle(3);

        // Reset mid-byte
        preamble(16);
        send_os(OS_SOP_PP, EV_SOP, 8'd2);
        send_sym(d5[7], EV_NONE, 8'd0);
        send_bit(1'b1, EV_NONE, 8'd0);
        send_bit(1'b0, EV_NONE, 8'd0);
        @(negedge clk);
        bit_vld = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("midrst_pulses", {sop_det, rx_data_vld, eop, hrst_det, crst_det, rx_err}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sop_type", sop_type, 0);
        chk("midrst_rx_data", rx_data, 0);
        rst = 1'b0;
        idle(2);

        // Recovery after reset
        preamble(16);
        send_os(OS_SOP, EV_SOP, 8'd0);
        send_sym(d5[10], EV_NONE, 8'd0);
        send_sym(d5[11], EV_DATA, 8'hBA);
        send_sym(K_EOP, EV_EOP, 8'd0);
        idle(4);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
